// File: rtl/conv_acc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : conv_acc_pkg
// Purpose  : Shared state encoding and index-width helper for the conv sequencer
// Revision : 1.0
// ============================================================================
package conv_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Index width for a counter spanning 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_wb_delay.sv
`default_nettype none
// ============================================================================
// Module   : conv_wb_delay
// Purpose  : LAT-stage valid+address shift register aligning write-back to the ALU
// Revision : 1.0
// ============================================================================
module conv_wb_delay #(
    parameter int LAT = 2,
    parameter int AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          empty
);

    logic [LAT-1:0] r_valid;
    logic [AW-1:0]  r_addr [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_valid[0] <= push;
            r_addr[0]  <= push_addr;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign out_valid = r_valid[LAT-1];
    assign out_addr  = r_addr[LAT-1];

    // Empty means nothing is queued behind the entry currently at the output,
    // so the line is guaranteed clear after this cycle.
    if (LAT == 1) begin : g_empty_single
        assign empty = 1'b1;
    end else begin : g_empty_multi
        assign empty = ~|r_valid[LAT-2:0];
    end

endmodule
`default_nettype wire

// File: rtl/conv_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_acc_sequencer
// Purpose  : Owns the row/column/channel/tap loop of a conv frame and issues
//            load, MAC, shift and latency-aligned write-back strobes
// Revision : 1.0
// ============================================================================
module conv_acc_sequencer
    import conv_acc_pkg::*;
#(
    parameter int KERNEL_TAPS = 9,
    parameter int OUT_COLS    = 6,
    parameter int OUT_ROWS    = 6,
    parameter int N_CH        = 4,
    parameter int ALU_LAT     = 2,
    localparam int W_TAP = idx_width(KERNEL_TAPS),
    localparam int W_COL = idx_width(OUT_COLS),
    localparam int W_ROW = idx_width(OUT_ROWS),
    localparam int W_CH  = idx_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic             load_ack,
    output logic             busy,
    output logic             done,
    output logic             load_req,
    output logic             alu_en,
    output logic             acc_clr,
    output logic [W_TAP-1:0] tap_idx,
    output logic [W_CH-1:0]  ch_idx,
    output logic             shift_en,
    output logic             wb_en,
    output logic [W_CH-1:0]  wb_ch,
    output logic [W_COL-1:0] wb_col,
    output logic [W_ROW-1:0] wb_row
);

    localparam int W_ADDR = W_CH + W_COL + W_ROW;

    localparam logic [W_TAP-1:0] c_TAP_LAST = W_TAP'(KERNEL_TAPS - 1);
    localparam logic [W_COL-1:0] c_COL_LAST = W_COL'(OUT_COLS - 1);
    localparam logic [W_ROW-1:0] c_ROW_LAST = W_ROW'(OUT_ROWS - 1);
    localparam logic [W_CH-1:0]  c_CH_LAST  = W_CH'(N_CH - 1);

    state_t           r_state, w_state_nxt;
    logic [W_TAP-1:0] r_tap,   w_tap_nxt;
    logic [W_CH-1:0]  r_ch,    w_ch_nxt;
    logic [W_COL-1:0] r_col,   w_col_nxt;
    logic [W_ROW-1:0] r_row,   w_row_nxt;

    logic              w_push;
    logic              w_dl_empty;
    logic              w_wb_valid;
    logic [W_ADDR-1:0] w_wb_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tap   <= '0;
            r_ch    <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tap   <= w_tap_nxt;
            r_ch    <= w_ch_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap;
        w_ch_nxt    = r_ch;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_push      = 1'b0;

        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        load_req = (r_state == ST_LOAD);
        alu_en   = (r_state == ST_CALC);
        acc_clr  = (r_state == ST_CALC) && (r_tap == '0);
        shift_en = (r_state == ST_SHIFT);
        tap_idx  = r_tap;
        ch_idx   = r_ch;

        case (r_state)
            ST_IDLE: begin
                w_tap_nxt = '0;
                w_ch_nxt  = '0;
                w_col_nxt = '0;
                w_row_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_tap_nxt = '0;
                w_ch_nxt  = '0;
                if (load_ack) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_tap == c_TAP_LAST) begin
                    // Accumulation complete: queue its write-back address.
                    w_push    = 1'b1;
                    w_tap_nxt = '0;
                    if (r_ch != c_CH_LAST) begin
                        w_ch_nxt = r_ch + 1'b1;
                    end else if (r_col != c_COL_LAST) begin
                        w_state_nxt = ST_SHIFT;
                    end else if (r_row != c_ROW_LAST) begin
                        w_row_nxt   = r_row + 1'b1;
                        w_col_nxt   = '0;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else begin
                    w_tap_nxt = r_tap + 1'b1;
                end
            end
            ST_SHIFT: begin
                w_col_nxt   = r_col + 1'b1;
                w_ch_nxt    = '0;
                w_state_nxt = ST_CALC;
            end
            ST_DRAIN: begin
                if (w_dl_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over every transition and cancels any push this cycle.
        if (clr) begin
            w_state_nxt = ST_IDLE;
            w_tap_nxt   = '0;
            w_ch_nxt    = '0;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_push      = 1'b0;
        end
    end

    conv_wb_delay #(
        .LAT (ALU_LAT),
        .AW  (W_ADDR)
    ) u_wb_delay (
        .clk       (clk),
        .rst       (rst),
        .flush     (clr),
        .push      (w_push),
        .push_addr ({r_ch, r_col, r_row}),
        .out_valid (w_wb_valid),
        .out_addr  (w_wb_addr),
        .empty     (w_dl_empty)
    );

    assign wb_en  = w_wb_valid;
    assign wb_ch  = w_wb_addr[W_ROW+W_COL +: W_CH];
    assign wb_col = w_wb_addr[W_ROW +: W_COL];
    assign wb_row = w_wb_addr[0 +: W_ROW];

endmodule
`default_nettype wire

// File: tb/tb_conv_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_acc_sequencer
// Purpose  : Scoreboard bench for conv_acc_sequencer (two parameter sets)
// Revision : 1.0
// ============================================================================
module tb_conv_acc_sequencer;
    import conv_acc_pkg::*;

    localparam int A_K = 2, A_COLS = 2, A_ROWS = 2, A_CH = 2, A_LAT = 2;
    localparam int B_K = 1, B_COLS = 3, B_ROWS = 1, B_CH = 1, B_LAT = 1;
    localparam int A_WT = idx_width(A_K), A_WC = idx_width(A_COLS);
    localparam int A_WR = idx_width(A_ROWS), A_WH = idx_width(A_CH);
    localparam int B_WT = idx_width(B_K), B_WC = idx_width(B_COLS);
    localparam int B_WR = idx_width(B_ROWS), B_WH = idx_width(B_CH);

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic start_a, clr_a, load_ack_a;
    logic busy_a, done_a, load_req_a, alu_en_a, acc_clr_a, shift_en_a, wb_en_a;
    logic [A_WT-1:0] tap_idx_a;
    logic [A_WH-1:0] ch_idx_a, wb_ch_a;
    logic [A_WC-1:0] wb_col_a;
    logic [A_WR-1:0] wb_row_a;

    logic start_b, clr_b, load_ack_b;
    logic busy_b, done_b, load_req_b, alu_en_b, acc_clr_b, shift_en_b, wb_en_b;
    logic [B_WT-1:0] tap_idx_b;
    logic [B_WH-1:0] ch_idx_b, wb_ch_b;
    logic [B_WC-1:0] wb_col_b;
    logic [B_WR-1:0] wb_row_b;

    logic [31:0] outs_a, outs_b;
    assign outs_a = 32'({busy_a, done_a, load_req_a, alu_en_a, acc_clr_a, tap_idx_a, ch_idx_a,
                         shift_en_a, wb_en_a, wb_ch_a, wb_col_a, wb_row_a});
    assign outs_b = 32'({busy_b, done_b, load_req_b, alu_en_b, acc_clr_b, tap_idx_b, ch_idx_b,
                         shift_en_b, wb_en_b, wb_ch_b, wb_col_b, wb_row_b});

    conv_acc_sequencer #(
        .KERNEL_TAPS(A_K), .OUT_COLS(A_COLS), .OUT_ROWS(A_ROWS), .N_CH(A_CH), .ALU_LAT(A_LAT)
    ) u_dut_a (
        .clk(clk), .rst(rst_n), .start(start_a), .clr(clr_a), .load_ack(load_ack_a),
        .busy(busy_a), .done(done_a), .load_req(load_req_a), .alu_en(alu_en_a),
        .acc_clr(acc_clr_a), .tap_idx(tap_idx_a), .ch_idx(ch_idx_a), .shift_en(shift_en_a),
        .wb_en(wb_en_a), .wb_ch(wb_ch_a), .wb_col(wb_col_a), .wb_row(wb_row_a)
    );

    conv_acc_sequencer #(
        .KERNEL_TAPS(B_K), .OUT_COLS(B_COLS), .OUT_ROWS(B_ROWS), .N_CH(B_CH), .ALU_LAT(B_LAT)
    ) u_dut_b (
        .clk(clk), .rst(rst_n), .start(start_b), .clr(clr_b), .load_ack(load_ack_b),
        .busy(busy_b), .done(done_b), .load_req(load_req_b), .alu_en(alu_en_b),
        .acc_clr(acc_clr_b), .tap_idx(tap_idx_b), .ch_idx(ch_idx_b), .shift_en(shift_en_b),
        .wb_en(wb_en_b), .wb_ch(wb_ch_b), .wb_col(wb_col_b), .wb_row(wb_row_b)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- DUT A scoreboard ----------------
    int exp_addr_a[$];
    int exp_time_a[$];
    int a_alu = 0, a_wb = 0, a_done = 0, a_shift = 0, a_last_wb = 0;
    int a_req_len = 0, a_exp_req_len = 1, a_ack_delay = 0, a_req_seen = 0;
    logic a_prev_req = 1'b0;

    task automatic flush_a();
        exp_addr_a.delete();
        exp_time_a.delete();
        a_alu      = 0;
        a_req_len  = 0;
        a_prev_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n || clr_a) begin
            flush_a();
        end else begin
            if (alu_en_a) begin
                check("a_tap", 32'(tap_idx_a), a_alu % A_K);
                check("a_ch", 32'(ch_idx_a), (a_alu / A_K) % A_CH);
                check("a_acc_clr", 32'(acc_clr_a), 32'((a_alu % A_K) == 0));
                if (a_alu % A_K == A_K - 1) exp_time_a.push_back(cyc + A_LAT);
                a_alu++;
            end
            if (shift_en_a) begin
                check("a_shift_pos", 32'((a_alu % (A_K*A_CH) == 0) && (a_alu % (A_K*A_CH*A_COLS) != 0)), 1);
                a_shift++;
            end
            if (wb_en_a) begin
                check("a_wb_expected", 32'(exp_addr_a.size() > 0), 1);
                if (exp_addr_a.size() > 0)
                    check("a_wb_addr", int'(wb_row_a)*100 + int'(wb_col_a)*10 + int'(wb_ch_a),
                          exp_addr_a.pop_front());
                check("a_wb_time_known", 32'(exp_time_a.size() > 0), 1);
                if (exp_time_a.size() > 0) check("a_wb_cycle", cyc, exp_time_a.pop_front());
                a_wb++;
                a_last_wb = cyc;
            end
            if (done_a) begin
                check("a_done_after_wb", cyc, a_last_wb + 1);
                a_done++;
            end
            if (load_req_a) begin
                a_req_len++;
            end else if (a_prev_req) begin
                check("a_req_len", a_req_len, a_exp_req_len);
                check("a_calc_after_ack", 32'(alu_en_a), 1);
                a_req_len = 0;
            end
            a_prev_req = load_req_a;
        end
    end

    // Acknowledge responder: ack on the a_ack_delay-th cycle of a request (0 = tied high).
    initial begin
        load_ack_a = 1'b0;
        forever begin
            @(negedge clk);
            if (load_req_a) a_req_seen++;
            else            a_req_seen = 0;
            load_ack_a = (a_ack_delay == 0) ? 1'b1 : (a_req_seen >= a_ack_delay);
        end
    end

    // ---------------- DUT B scoreboard ----------------
    int exp_col_b[$];
    int exp_time_b[$];
    int b_alu = 0, b_wb = 0, b_done = 0, b_last_wb = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_col_b.delete();
            exp_time_b.delete();
        end else begin
            if (alu_en_b) begin
                check("b_acc_clr", 32'(acc_clr_b), 1);
                check("b_tap", 32'(tap_idx_b), 0);
                exp_time_b.push_back(cyc + B_LAT);
                b_alu++;
            end
            if (wb_en_b) begin
                check("b_wb_expected", 32'(exp_col_b.size() > 0), 1);
                if (exp_col_b.size() > 0) check("b_wb_col", 32'(wb_col_b), exp_col_b.pop_front());
                check("b_wb_time_known", 32'(exp_time_b.size() > 0), 1);
                if (exp_time_b.size() > 0) check("b_wb_cycle", cyc, exp_time_b.pop_front());
                b_wb++;
                b_last_wb = cyc;
            end
            if (done_b) begin
                check("b_done_after_wb", cyc, b_last_wb + 1);
                b_done++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic arm_frame_a(input int ack_delay);
        a_ack_delay   = ack_delay;
        a_exp_req_len = (ack_delay == 0) ? 1 : ack_delay;
        exp_addr_a.delete();
        exp_time_a.delete();
        for (int r = 0; r < A_ROWS; r++)
            for (int c = 0; c < A_COLS; c++)
                for (int h = 0; h < A_CH; h++)
                    exp_addr_a.push_back(r*100 + c*10 + h);
        a_wb = 0; a_done = 0; a_shift = 0; a_alu = 0;
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk); #1;
        check("a_start_latency", 32'(load_req_a), 1);
        check("a_busy", 32'(busy_a), 1);
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (a_done == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("a_done_seen", 32'(a_done > 0), 1);
    endtask

    task automatic run_frame_a(input int ack_delay, input bit poke_start);
        arm_frame_a(ack_delay);
        pulse_start_a();
        if (poke_start) begin
            repeat (6) @(posedge clk);
            #1 start_a = 1'b1;
            @(posedge clk); #1 start_a = 1'b0;
        end
        wait_done_a(400);
        check("a_wb_count", a_wb, A_ROWS*A_COLS*A_CH);
        check("a_alu_count", a_alu, A_ROWS*A_COLS*A_CH*A_K);
        check("a_shift_count", a_shift, A_ROWS*(A_COLS-1));
        check("a_addr_queue_empty", exp_addr_a.size(), 0);
        repeat (4) @(negedge clk);
        #1;
        check("a_idle_after_done", 32'(busy_a), 0);
        check("a_done_once", a_done, 1);
    endtask

    task automatic clr_test_a();
        int n = 0;
        int d0, w0;
        arm_frame_a(0);
        pulse_start_a();
        while (a_alu < A_K*A_CH*A_COLS + 2 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("a_reached_row1", 32'(a_alu >= A_K*A_CH*A_COLS + 2), 1);
        @(posedge clk); #1 clr_a = 1'b1;
        @(posedge clk); #1 clr_a = 1'b0;
        check("a_clr_idle", 32'(busy_a), 0);
        check("a_clr_outputs", outs_a, 0);
        d0 = a_done;
        w0 = a_wb;
        repeat (12) @(negedge clk);
        #1;
        check("a_clr_no_wb", a_wb, w0);
        check("a_clr_no_done", a_done, d0);
    endtask

    task automatic reset_test_a();
        int n = 0;
        arm_frame_a(0);
        pulse_start_a();
        while (!shift_en_a && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("a_reached_shift", 32'(shift_en_a), 1);
        rst_n = 1'b0;
        #1;
        check("a_async_rst_outputs", outs_a, 0);
        flush_a();
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("a_rst_stays_idle", outs_a, 0);
    endtask

    task automatic run_frame_b();
        int n = 0;
        exp_col_b.delete();
        exp_time_b.delete();
        for (int c = 0; c < B_COLS; c++) exp_col_b.push_back(c);
        b_alu = 0; b_wb = 0; b_done = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        while (b_done == 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("b_done_seen", 32'(b_done > 0), 1);
        check("b_wb_count", b_wb, B_ROWS*B_COLS*B_CH);
        check("b_alu_count", b_alu, B_ROWS*B_COLS*B_CH*B_K);
        repeat (3) @(negedge clk);
        #1;
        check("b_idle_after_done", 32'(busy_b), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; clr_a = 1'b0;
        start_b = 1'b0; clr_b = 1'b0; load_ack_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("a_reset_outputs", outs_a, 0);
        check("b_reset_outputs", outs_b, 0);
        rst_n = 1'b1;

        run_frame_b();
        run_frame_a(0, 1'b0);
        run_frame_a(5, 1'b1);
        clr_test_a();
        run_frame_a(0, 1'b0);
        reset_test_a();
        run_frame_a(0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
